// File: rtl/tidc_req_arbiter_pkg.sv
// Shared TIDC request codes and sizing constants.
// Provides the L1 request type codes (L1_REQ_*), the permission transfer
// codes (PARAM_*), the cache-line offset width and the requester count.
package tidc_params;

    localparam int unsigned TIDC_NUM_L1 = 2;
    localparam int unsigned LINE_OFF    = 5;

    localparam logic [2:0] L1_REQ_ACQUIRE_BLOCK  = 3'd0;
    localparam logic [2:0] L1_REQ_ACQUIRE_PERM   = 3'd1;
    localparam logic [2:0] L1_REQ_RELEASE        = 3'd2;
    localparam logic [2:0] L1_REQ_RELEASE_DATA   = 3'd3;
    localparam logic [2:0] L1_REQ_PROBE_ACK      = 3'd4;
    localparam logic [2:0] L1_REQ_PROBE_ACK_DATA = 3'd5;

    localparam logic [2:0] PARAM_NTOB = 3'd0;
    localparam logic [2:0] PARAM_NTOT = 3'd1;
    localparam logic [2:0] PARAM_BTOT = 3'd2;
    localparam logic [2:0] PARAM_TTOB = 3'd3;
    localparam logic [2:0] PARAM_TTON = 3'd4;
    localparam logic [2:0] PARAM_BTON = 3'd5;

endpackage

// File: rtl/tidc_req_arbiter_if.sv
// Arbiter <-> coherence engine request/completion bus.
//   out_valid/out_ready : request handshake towards the engine
//   out_id              : requester index of the out_* payload
//   out_addr/type/perm/data : granted request payload
//   cmpl_valid/cmpl_id  : engine reports a finished transaction
// master = arbiter side, slave = engine side.
interface tidc_req_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
);
    logic              out_valid;
    logic              out_ready;
    logic              out_id;
    logic [ADDR_W-1:0] out_addr;
    logic [2:0]        out_type;
    logic [2:0]        out_perm;
    logic [DATA_W-1:0] out_data;
    logic              cmpl_valid;
    logic              cmpl_id;

    modport master (
        output out_valid, out_id, out_addr, out_type, out_perm, out_data,
        input  out_ready, cmpl_valid, cmpl_id
    );

    modport slave (
        input  out_valid, out_id, out_addr, out_type, out_perm, out_data,
        output out_ready, cmpl_valid, cmpl_id
    );
endinterface

// File: rtl/tidc_req_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   elig       : per-requester eligibility
//   last_grant : index granted most recently (held by the parent)
//   gnt_valid  : at least one requester eligible
//   gnt_idx    : chosen requester; on a tie the one that did not win last
module tidc_rr_pick2
    import tidc_params::*;
(
    input  logic [TIDC_NUM_L1-1:0] elig,
    input  logic                   last_grant,
    output logic                   gnt_valid,
    output logic                   gnt_idx
);
    always_comb begin
        gnt_valid = |elig;
        if (&elig) gnt_idx = ~last_grant;
        else       gnt_idx = elig[1];
    end
endmodule

// File: rtl/tidc_req_arbiter.sv
// Two-requester arbiter between the L1_0/L1_1 request adapters and the TIDC
// coherence engine request port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (bit i = L1_i); ready is
//                         combinational and high only in the grant cycle
//   req_addr/type/perm/data_{0,1} : per-requester payload
//   eng                 : registered request output + completion input
//   busy                : registered outstanding flag per requester
//   err_spurious        : one-cycle pulse on completion for an idle requester
// One outstanding transaction per requester; a request hitting the line the
// other requester has in flight waits until that transaction completes.
module tidc_req_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned LINE_OFF = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [tidc_params::TIDC_NUM_L1-1:0] req_valid,
    output logic [tidc_params::TIDC_NUM_L1-1:0] req_ready,
    input  logic [ADDR_W-1:0]                  req_addr_0,
    input  logic [ADDR_W-1:0]                  req_addr_1,
    input  logic [2:0]                         req_type_0,
    input  logic [2:0]                         req_type_1,
    input  logic [2:0]                         req_perm_0,
    input  logic [2:0]                         req_perm_1,
    input  logic [DATA_W-1:0]                  req_data_0,
    input  logic [DATA_W-1:0]                  req_data_1,
    tidc_req_arbiter_if.master                 eng,
    output logic [tidc_params::TIDC_NUM_L1-1:0] busy,
    output logic                               err_spurious
);
    localparam int unsigned LINE_W = ADDR_W - LINE_OFF;

    logic [tidc_params::TIDC_NUM_L1-1:0] busy_q, busy_nxt, elig;
    logic [LINE_W-1:0] line0_q, line1_q;
    logic [LINE_W-1:0] req_line0, req_line1;
    logic              last_grant_q;
    logic              slot_free, gnt_valid, gnt_idx, grant;

    assign req_line0 = req_addr_0[ADDR_W-1:LINE_OFF];
    assign req_line1 = req_addr_1[ADDR_W-1:LINE_OFF];

    // Eligibility only looks at registered busy/line, so a completion in the
    // current cycle unblocks its own or the other requester one cycle later.
    assign elig[0] = req_valid[0] & ~busy_q[0] & ~(busy_q[1] & (req_line0 == line1_q));
    assign elig[1] = req_valid[1] & ~busy_q[1] & ~(busy_q[0] & (req_line1 == line0_q));

    assign slot_free = ~eng.out_valid | eng.out_ready;

    tidc_rr_pick2 u_pick (
        .elig       (elig),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    assign grant     = slot_free & gnt_valid;
    assign req_ready = grant ? (gnt_idx ? 2'b10 : 2'b01) : '0;
    assign busy      = busy_q;

    always_comb begin
        busy_nxt = busy_q;
        if (eng.cmpl_valid && busy_q[eng.cmpl_id]) busy_nxt[eng.cmpl_id] = 1'b0;
        if (grant) busy_nxt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng.out_valid <= 1'b0;
            eng.out_id    <= 1'b0;
            eng.out_addr  <= '0;
            eng.out_type  <= '0;
            eng.out_perm  <= '0;
            eng.out_data  <= '0;
            busy_q        <= '0;
            line0_q       <= '0;
            line1_q       <= '0;
            last_grant_q  <= 1'b1;
            err_spurious  <= 1'b0;
        end else begin
            busy_q       <= busy_nxt;
            err_spurious <= eng.cmpl_valid & ~busy_q[eng.cmpl_id];
            if (grant) begin
                eng.out_valid <= 1'b1;
                eng.out_id    <= gnt_idx;
                eng.out_addr  <= gnt_idx ? req_addr_1 : req_addr_0;
                eng.out_type  <= gnt_idx ? req_type_1 : req_type_0;
                eng.out_perm  <= gnt_idx ? req_perm_1 : req_perm_0;
                eng.out_data  <= gnt_idx ? req_data_1 : req_data_0;
                last_grant_q  <= gnt_idx;
                if (gnt_idx) line1_q <= req_line1;
                else         line0_q <= req_line0;
            end else if (eng.out_ready) begin
                eng.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tidc_req_arbiter.md
Name: tidc_req_arbiter

Overview:
- Two-requester arbiter between the L1_0/L1_1 request adapters and the single TIDC coherence engine request port.
- Round-robin grant with a registered output stage.
- Enforces one outstanding transaction per requester.
- Blocks a request whose cache line matches the other requester's in-flight line until that transaction completes, which serialises same-line upgrades such as the S->T probe case.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 256, cache line / request data width
- LINE_OFF, 5, low address bits ignored for line compare (32-byte lines)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester request valid (bit i = L1_i)
- req_ready  out  2  per-requester accept; combinational; high only in grant cycle
- req_addr_0 / req_addr_1  in  ADDR_W  request address
- req_type_0 / req_type_1  in  3  L1_REQ_* code
- req_perm_0 / req_perm_1  in  3  PARAM_* code
- req_data_0 / req_data_1  in  DATA_W  write data
- out_valid  out  1  request to coherence engine
- out_ready  in  1  engine accepts
- out_id  out  1  requester index of out_* payload
- out_addr  out  ADDR_W  granted address
- out_type  out  3  granted type
- out_perm  out  3  granted permissions
- out_data  out  DATA_W  granted data
- cmpl_valid  in  1  engine reports transaction finished (data returned to L1)
- cmpl_id  in  1  requester index of completion
- busy  out  2  registered outstanding flags
- err_spurious  out  1  one-cycle pulse: completion for non-outstanding requester

Behaviour:
- Reset values: out_valid=0, out_id=0, out_addr/type/perm/data=0, busy=2'b00, err_spurious=0, last_grant=1 (so requester 0 wins first tie).
- State per requester i: busy[i] (outstanding), line_i = addr[ADDR_W-1:LINE_OFF] captured at grant.
- Eligibility: elig[i] = req_valid[i] & ~busy[i] & ~(busy[j] & line(req_addr_i)==line_j), j = other requester. All terms use registered busy/line.
- Slot free: slot_free = ~out_valid | out_ready.
- Grant (only when slot_free):
  - one requester eligible -> grant it;
  - both eligible -> grant the requester != last_grant.
- On grant:
  - req_ready[g]=1 in the same cycle.
  - Output register loads payload and out_id=g; out_valid=1 next cycle.
  - busy[g]<=1, line_g captured, last_grant<=g.
- Output handshake: out_* payload is stable while out_valid & ~out_ready. out_valid drops the cycle after acceptance unless a new grant reloads it (back-to-back allowed, no bubble).
- Completion:
  - cmpl_valid & busy[cmpl_id] -> busy[cmpl_id]<=0.
  - cmpl_valid & ~busy[cmpl_id] -> no state change; err_spurious=1 next cycle.
- Simultaneous completion and request, same requester: grant uses the old busy, so no grant that cycle; earliest re-grant is the next cycle (one-cycle bubble, required).
- Simultaneous completion of i and blocked request of j to the same line: j is still blocked this cycle and eligible next cycle.
- Requester deasserts req_valid before ready: permitted; nothing is captured.
- No starvation: with both persistently eligible, grants alternate strictly.
- Asynchronous reset mid-transaction: busy cleared, out_valid cleared, in-flight request dropped. The engine is reset with it.

Decomposition:
- Shared package tidc_params: L1_REQ_*, PARAM_* codes, LINE_OFF, and requester-count constant TIDC_NUM_L1=2.
- One natural sub-module, tidc_rr_pick2: a 2-way round-robin picker with inputs elig[1:0] and last_grant, outputs gnt_valid and gnt_idx. It is combinational; last_grant stays in the parent.
- The output register and busy/line tracking stay in the parent.

Test Plan:
- Reset release, req_valid=2'b11, different lines 0x1000/0x2000, out_ready=1 -> grants L1_0 cycle 1, L1_1 cycle 2; out_id 0 then 1; busy=2'b11.
- L1_0 busy on 0x1000; L1_1 requests 0x1010 (same line) -> req_ready[1]=0 until cmpl_valid,cmpl_id=0; granted the cycle after completion with out_addr=0x1010.
- out_ready=0 for 5 cycles with out_valid=1 -> out_addr/type/perm/data unchanged, no req_ready pulses; out_ready=1 -> one transfer, next grant the same cycle.
- Both requesters continuously valid, distinct lines, completion 2 cycles after each acceptance, over 20 grants -> out_id strictly alternates 0,1,0,1...
- cmpl_valid=1, cmpl_id=1 while busy=2'b01 -> err_spurious=1 for exactly one cycle, busy stays 2'b01.
- rst_n=0 asserted asynchronously while out_valid=1, busy=2'b11 -> out_valid=0 and busy=0 immediately; after release, L1_0 wins the first tie.
